// File: rtl/gpr_scoreboard.sv
// Issue-side hazard controller for the 32x64 GPR file.
// Each register has a saturating counter of in-flight writes. An instruction
// issues only when both of its sources are free and its destination counter
// still has room. Writeback releases become visible one cycle after commit.
module gpr_scoreboard #(
    parameter int GPR_NUM = 32,
    parameter int GPR_W   = 5,
    parameter int CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [GPR_W-1:0] issue_rs1,
    input  logic             issue_rs1_en,
    input  logic [GPR_W-1:0] issue_rs2,
    input  logic             issue_rs2_en,
    input  logic [GPR_W-1:0] issue_rd,
    input  logic             issue_rd_en,
    input  logic             wb_valid,
    input  logic [GPR_W-1:0] wb_rd,
    input  logic             flush,
    output logic             busy_any,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Counters exist only for x1..x(GPR_NUM-1); cnt_view adds a constant zero for x0
    logic [CNT_W-1:0] cnt_reg  [1:GPR_NUM-1];
    logic [CNT_W-1:0] cnt_next [1:GPR_NUM-1];
    logic [CNT_W-1:0] cnt_view [GPR_NUM];
    logic [GPR_NUM-1:0] busy_vec;
    logic err_reg;
    logic err_next;

    logic fire;
    logic h1;
    logic h2;
    logic hsat;
    logic dec_any;

    // Hazards look only at registered counts, so a same-cycle writeback never bypasses
    always_comb begin
        h1   = issue_rs1_en & (issue_rs1 != '0) & (cnt_view[issue_rs1] != CNT_ZERO);
        h2   = issue_rs2_en & (issue_rs2 != '0) & (cnt_view[issue_rs2] != CNT_ZERO);
        hsat = issue_rd_en  & (issue_rd  != '0) & (cnt_view[issue_rd]  == CNT_MAX);
        issue_ready = ~rst & ~flush & ~h1 & ~h2 & ~hsat;
        fire        = issue_valid & issue_ready;
        dec_any     = wb_valid & (wb_rd != '0);
        // A commit to a register with nothing pending is a protocol error
        err_next    = err_reg | (dec_any & (cnt_view[wb_rd] == CNT_ZERO));
    end

    genvar gi;
    generate
        for (gi = 0; gi < GPR_NUM; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign cnt_view[gi] = CNT_ZERO;
                assign busy_vec[gi] = 1'b0;
            end else begin : g_cnt
                logic inc_sel;
                logic dec_sel;
                assign inc_sel      = fire & issue_rd_en & (issue_rd == GPR_W'(gi));
                assign dec_sel      = wb_valid & (wb_rd == GPR_W'(gi));
                assign cnt_view[gi] = cnt_reg[gi];
                assign busy_vec[gi] = (cnt_reg[gi] != CNT_ZERO);

                // Issue and commit to the same register cancel; a decrement never wraps below zero
                always_comb begin
                    cnt_next[gi] = cnt_reg[gi];
                    if (inc_sel && !dec_sel) begin
                        cnt_next[gi] = cnt_reg[gi] + CNT_ONE;
                    end else if (dec_sel && !inc_sel && (cnt_reg[gi] != CNT_ZERO)) begin
                        cnt_next[gi] = cnt_reg[gi] - CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    // Counter and error state; reset beats flush, flush discards this cycle's events
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < GPR_NUM; i++) cnt_reg[i] <= CNT_ZERO;
            err_reg <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < GPR_NUM; i++) cnt_reg[i] <= CNT_ZERO;
        end else begin
            for (int i = 1; i < GPR_NUM; i++) cnt_reg[i] <= cnt_next[i];
            err_reg <= err_next;
        end
    end

    assign busy_any = |busy_vec;
    assign err      = err_reg;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Randomised and directed bench for gpr_scoreboard. A behavioural model of
// pending writes predicts issue_ready/busy_any/err each cycle; predictions are
// queued and a separate monitor compares them against the DUT.
module tb_gpr_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [4:0] issue_rs1 = '0;
    logic       issue_rs1_en = 1'b0;
    logic [4:0] issue_rs2 = '0;
    logic       issue_rs2_en = 1'b0;
    logic [4:0] issue_rd = '0;
    logic       issue_rd_en = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_rd = '0;
    logic       flush = 1'b0;
    logic       busy_any;
    logic       err;

    gpr_scoreboard #(.GPR_NUM(32), .GPR_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
        .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .busy_any(busy_any), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        bit busy;
        bit err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: number of outstanding writes per register, plus sticky error
    int m_cnt[32];
    bit m_err;
    localparam int MAXP = 3;

    function automatic bit pending(input int r);
        return (r != 0) && (m_cnt[r] > 0);
    endfunction

    function automatic bit model_ready();
        bit blocked;
        blocked = (issue_rs1_en && pending(int'(issue_rs1))) ||
                  (issue_rs2_en && pending(int'(issue_rs2))) ||
                  (issue_rd_en && issue_rd != 0 && m_cnt[issue_rd] >= MAXP);
        return !rst && !flush && !blocked;
    endfunction

    function automatic bit model_busy();
        for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of stimulus: drive, predict, then advance the model at the edge
    task automatic step(input bit r, input bit v,
                        input int rs1, input bit e1, input int rs2, input bit e2,
                        input int rd, input bit ed, input bit wv, input int wr,
                        input bit f);
        exp_t e;
        bit   rdy;
        @(negedge clk);
        rst = r; issue_valid = v;
        issue_rs1 = 5'(rs1); issue_rs1_en = e1;
        issue_rs2 = 5'(rs2); issue_rs2_en = e2;
        issue_rd  = 5'(rd);  issue_rd_en  = ed;
        wb_valid  = wv; wb_rd = 5'(wr); flush = f;
        #1;
        rdy = model_ready();
        e.ready = rdy; e.busy = model_busy(); e.err = m_err; e.cyc = cyc;
        exp_q.push_back(e);
        $display("cyc=%0d rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b wb=%0b/%0d fl=%0b exp_rdy=%0b",
                 cyc, r, v, rs1, e1, rs2, e2, rd, ed, wv, wr, f, rdy);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else if (f) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            bit inc, dec;
            inc = v && rdy && ed && rd != 0;
            dec = wv && wr != 0;
            if (dec && m_cnt[wr] == 0) m_err = 1'b1;
            if (!(inc && dec && rd == wr)) begin
                if (inc) m_cnt[rd]++;
                if (dec && m_cnt[wr] > 0) m_cnt[wr]--;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input bit got, input bit want, input int c);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", name, c, got, want);
        end
    endtask

    // Monitor: the DUT presents all three outputs every cycle; compare with the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_ready", issue_ready, e.ready, e.cyc);
                chk("busy_any",    busy_any,    e.busy,  e.cyc);
                chk("err",         err,         e.err,   e.cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;

        // Reset, then idle with x5/x6/x7 enables
        step(1, 0, 5, 1, 6, 1, 7, 1, 0, 0, 0);
        step(1, 1, 5, 1, 6, 1, 7, 1, 1, 3, 1);
        step(0, 0, 5, 1, 6, 1, 7, 1, 0, 0, 0);

        // RAW stall on x5, released one cycle after writeback
        step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 8, 1, 1, 5, 0);
        step(0, 1, 5, 1, 0, 0, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0);

        // x0 never stalls and never counts
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // Saturation on x9
        repeat (4) step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        step(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);

        // Same-register issue and commit, then flush
        step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 3, 1, 1, 3, 0);
        step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 4, 1, 1, 3, 1);
        idle();

        // Underflow on x12 is sticky until reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        idle();
        step(0, 1, 12, 1, 0, 0, 12, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // Random traffic over a small register window so hazards are frequent
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 59) == 0);
        end

        @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
